// File: rtl/tx_byte_queue_if.sv
// Write port, status flags and transmitter START/BUSY/DATA handshake of the tx byte queue.
interface tx_byte_queue_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_ovf;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_busy,
        input  full, empty, count, overflow, tx_start, tx_data
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_busy,
        output full, empty, count, overflow, tx_start, tx_data
    );
endinterface

// File: rtl/tx_byte_queue.sv
// Byte FIFO feeding the UART transmitter one frame at a time via a START/BUSY handshake.
//   state     | meaning
//   S_IDLE    | waiting for a queued byte and an idle transmitter; pops on exit
//   S_START   | TX_START pulse cycle
//   S_WAIT_HI | waiting for the transmitter to raise BUSY
//   S_WAIT_LO | frame on the line, waiting for BUSY to drop
module tx_byte_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    tx_byte_queue_if.slave   io_q
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_WAIT_HI = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = io_q.wr_en && !w_full;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // BUSY may still be high from a frame started before a reset
                if (!w_empty && !io_q.tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START:   w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (io_q.tx_busy)  w_state_nxt = S_WAIT_LO;
            S_WAIT_LO: if (!io_q.tx_busy) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_q.wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (io_q.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (io_q.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign io_q.full     = w_full;
    assign io_q.empty    = w_empty;
    assign io_q.count    = r_count;
    assign io_q.overflow = r_overflow;
    assign io_q.tx_start = r_tx_start;
    assign io_q.tx_data  = r_tx_data;
endmodule

// File: doc/tx_byte_queue.md
# tx_byte_queue

Byte queue and start sequencer directly upstream of the UART transmitter. Filter logic writes bytes at any rate up to one per clock. The block buffers them in a FIFO and hands them one at a time to the transmitter through its START/BUSY/DATA handshake, so no byte is dropped while a frame is on the line. Writes to a full queue are discarded and flagged.

## Interface
- DEPTH, 16: FIFO depth in bytes; power of two, ≥2.
- ADDR_W, 4: log2(DEPTH).
- CLK  in  1  system clock (50 MHz).
- RST  in  1  asynchronous, active-high reset.
- WR_EN  in  1  write strobe; WR_DATA is enqueued on a rising CLK edge with WR_EN=1 and FULL=0.
- WR_DATA  in  8  byte to enqueue.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- COUNT  out  ADDR_W+1  bytes currently queued (0..DEPTH).
- OVERFLOW  out  1  sticky; set by a write attempted while FULL.
- CLR_OVF  in  1  clears OVERFLOW; set takes priority when both occur in the same cycle.
- TX_BUSY  in  1  transmitter BUSY.
- TX_START  out  1  one-cycle start pulse to the transmitter.
- TX_DATA  out  8  byte presented to the transmitter; held stable from pop until the next pop.

## Operation
- Storage: DEPTH×8 array; ADDR_W-bit read and write pointers wrap modulo DEPTH; separate COUNT register.
- Push: WR_EN & !FULL writes mem[wr_ptr], then wr_ptr+1.
- Pop: occurs only in the IDLE→START transition. It loads TX_DATA ← mem[rd_ptr], then rd_ptr+1.
- COUNT: +1 on push only, −1 on pop only, unchanged on push+pop in the same cycle.
- A write while FULL is dropped and sets OVERFLOW, even if a pop occurs in the same cycle. Pointers and COUNT are unchanged by the dropped write.
- FSM:
  - IDLE: if !EMPTY & !TX_BUSY, pop and go to START; else stay.
  - START: TX_START=1 for exactly this cycle; go to WAIT_HI.
  - WAIT_HI: stay until TX_BUSY=1, then go to WAIT_LO. The transmitter raises BUSY the cycle after it samples START.
  - WAIT_LO: stay until TX_BUSY=0, then go to IDLE.
- No timeout. A transmitter that never raises BUSY stalls the FSM in WAIT_HI; this is accepted behaviour.
- Reset values: state IDLE, pointers 0, COUNT 0, EMPTY 1, FULL 0, OVERFLOW 0, TX_START 0, TX_DATA 8'h00. Queued bytes are lost.
- Reset mid-frame: the transmitter has no reset and may still be BUSY. IDLE's !TX_BUSY condition ensures no START is issued until that frame ends.

## Timing
- All outputs are registered, except that FULL, EMPTY and COUNT may be decoded combinationally from the COUNT register.
- Write at edge k into an empty queue with an idle transmitter:
  - EMPTY falls after edge k.
  - Pop at edge k+1; TX_START is high for the cycle k+1→k+2, with TX_DATA already valid.
- TX_START is never high for two consecutive cycles. It is never asserted while TX_BUSY=1.
- Back-to-back frames: after TX_BUSY falls at edge m, the next TX_START is high in cycle m+2→m+3 (WAIT_LO→IDLE, then the pop).
- Throughput is bounded by the transmitter: 10 bits × 5208 clocks ≈ 52080 clocks per byte.

## Test plan
- Reset sequencing: assert RST mid-queue with COUNT=5 and the FSM in WAIT_LO → all outputs return to their reset values immediately; no TX_START until TX_BUSY is low; after release, EMPTY=1.
- Single byte: write 8'hA5 at edge 0 → TX_START high in cycle 1→2, TX_DATA=8'hA5; the transmitter model frames 0,1,0,1,0,0,1,0,1,1 (start bit, LSB first, stop bit); EMPTY=1 from edge 1.
- Burst: write 8'h00–8'h0F back-to-back (DEPTH=16) → FULL never asserts (first byte popped early); exactly 16 START pulses, in order; no pulse overlaps BUSY.
- Overflow: hold TX_BUSY=1, write 17 bytes → FULL=1, COUNT=16, OVERFLOW=1, 17th byte absent from output; CLR_OVF → OVERFLOW=0 next cycle.
- Full with concurrent pop: at COUNT=16, release BUSY so a pop coincides with WR_EN → write dropped, OVERFLOW=1, COUNT=15.
- Pointer wrap: stream 40 random bytes with random WR_EN gaps → output sequence equals input sequence; COUNT never exceeds 16 or goes below 0.
